eth_rx_udp_filter: RTL
======================

ETH_RX_UDP_FILTER -- requirements
Module: eth_rx_udp_filter

Interface
REQ-001 SHALL have parameter UDP_PORT, default 16'h3000, UDP destination port accepted as NetTLP traffic.
REQ-002 SHALL have parameter FIFO_AW, default 4, beat FIFO address width (depth 2**FIFO_AW).
REQ-003 SHALL have port clk156  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst156  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports s_axis_tvalid/tlast (1), s_axis_tkeep (8), s_axis_tdata (64), s_axis_tuser (1), all inputs: 10G MAC RX stream, no tready, first wire byte in tdata[7:0] / tkeep[0].
REQ-006 SHALL have ports m_axis_tvalid/tlast (1), m_axis_tkeep (8), m_axis_tdata (64), m_axis_tuser (1), all outputs: filtered stream, same byte order, no tready.
REQ-007 SHALL have outputs pass_frames (32) and drop_frames (32): frame counters.

Function
REQ-008 SHALL index input beats per frame from 0; beat 0 is the first valid beat after reset or after a tlast beat.
REQ-009 SHALL pass a frame only if: bytes 12-13 (beat1 bytes 4-5) = 08 00; byte 14 (beat1 byte 6) = 8'h45; byte 23 (beat2 byte 7) = 8'h11; bytes 36-37 (beat4 bytes 4-5) = UDP_PORT big-endian; tlast not seen on beats 0-4.
REQ-010 SHALL implement states HDR (reset state), PASS, DROP.
REQ-011 HDR: write every valid beat into the FIFO uncommitted, latch field-compare results per beat.
REQ-012 HDR, beat 4 valid without tlast, all checks true -> PASS, commit all frame beats including beat 4.
REQ-013 HDR, beat 4 valid without tlast, any check false -> DROP, rewind write pointer to frame start pointer.
REQ-014 HDR, beat 4 valid with tlast, checks true -> commit, stay HDR (frame complete, passed).
REQ-015 HDR, tlast on beats 0-3 (runt) -> rewind write pointer, stay HDR, count as dropped.
REQ-016 PASS: write and commit each valid beat in the same cycle; on tlast -> HDR, frame start pointer = next write address.
REQ-017 DROP: discard valid beats without writing; on tlast -> HDR.
REQ-018 SHALL emit one committed beat per cycle while read pointer != commit pointer; outputs registered; tuser/tkeep/tlast forwarded unmodified (bad-FCS frames passed with tuser=0).
REQ-019 Latency: beat 0 of a passing frame appears on m_axis the cycle after beat 4 is accepted; subsequent beats on consecutive cycles when available.
REQ-020 m_axis_tvalid SHALL be 0 on cycles with no committed beat; other m_axis outputs hold their last value when invalid.
REQ-021 Pointers SHALL be FIFO_AW+1 bits, wrap modulo 2**(FIFO_AW+1); uncommitted beats never emitted.
REQ-022 Rewind and a read in the same cycle SHALL both take effect; rewind never moves below the commit pointer.
REQ-023 pass_frames SHALL increment once per frame on its commit event (REQ-012/014); drop_frames once per frame on its drop event (REQ-013/015); both wrap at 2**32.
REQ-024 Input tvalid gaps SHALL not advance beat index, state, or pointers.

Reset
REQ-025 sys_rst156 high SHALL immediately force: state HDR, all pointers 0, beat index 0, m_axis_tvalid/tlast/tuser 0, m_axis_tdata/tkeep 0, pass_frames/drop_frames 0.
REQ-026 Reset asserted mid-frame SHALL discard buffered beats; first valid beat after release is beat 0.

Verification
REQ-027 60-byte UDP/IPv4 frame, dport 0x3000, back-to-back beats -> 8 beats out, first 1 cycle after beat 4 in, data bit-identical, pass_frames=1.
REQ-028 Same frame, dport 0x3001 -> m_axis_tvalid never 1, drop_frames=1, pass_frames=0.
REQ-029 ARP frame (ethertype 0806) followed immediately by passing frame -> only second frame emitted, counters 1/1.
REQ-030 32-byte runt (tlast on beat 3) -> nothing emitted, drop_frames=1; next valid frame passes intact.
REQ-031 Passing frame with tvalid low every other cycle and final beat tuser=0 -> all beats emitted in order, last with tuser=0, pass_frames=1.
REQ-032 Reset pulse during beat 2 of a passing frame -> no output, counters 0; subsequent frame passes with beat 0 aligned correctly.

Source files
------------

// File: rtl/eth_rx_udp_filter.sv
// NetTLP receive filter: passes IPv4/UDP frames to one destination port.
// Header beats are buffered uncommitted until the port check resolves.
module eth_rx_udp_filter #(
  parameter logic [15:0] UDP_PORT = 16'h3000,
  parameter int          FIFO_AW  = 4
) (
  input  logic        clk156,
  input  logic        sys_rst156,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic [7:0]  s_axis_tkeep,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tuser,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic [7:0]  m_axis_tkeep,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tuser,
  output logic [31:0] pass_frames,
  output logic [31:0] drop_frames
);

  localparam int PW = FIFO_AW + 1;
  localparam int DW = 74;

  typedef enum logic [1:0] {HDR, PASS, DROP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      beat_q, beat_d;
  logic            ok_q, ok_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   cm_q, cm_d;
  logic [PW-1:0]   rd_q;
  logic [31:0]     pass_q, pass_d;
  logic [31:0]     drop_q, drop_d;
  logic            we;
  logic            chk;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   mem [2**FIFO_AW];

  logic            mv_q, ml_q, mu_q;
  logic [7:0]      mk_q;
  logic [63:0]     md_q;

  assign wdata = {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};

  // Field compare for the header beat currently on the input
  always_comb begin
    chk = 1'b1;
    case (beat_q)
      3'd1: chk = (s_axis_tdata[39:32] == 8'h08) &&
                  (s_axis_tdata[47:40] == 8'h00) &&
                  (s_axis_tdata[55:48] == 8'h45);
      3'd2: chk = (s_axis_tdata[63:56] == 8'h11);
      3'd4: chk = (s_axis_tdata[39:32] == UDP_PORT[15:8]) &&
                  (s_axis_tdata[47:40] == UDP_PORT[7:0]);
      default: chk = 1'b1;
    endcase
  end

  // Next-state: header verdict, commit/rewind and frame counters
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ok_d    = ok_q;
    wr_d    = wr_q;
    cm_d    = cm_q;
    pass_d  = pass_q;
    drop_d  = drop_q;
    we      = 1'b0;
    if (s_axis_tvalid) begin
      case (state_q)
        HDR: begin
          we     = 1'b1;
          wr_d   = wr_q + 1'b1;
          ok_d   = ok_q & chk;
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd4) begin
            beat_d = 3'd0;
            ok_d   = 1'b1;
            if (ok_q && chk) begin
              cm_d    = wr_q + 1'b1;
              pass_d  = pass_q + 32'd1;
              state_d = s_axis_tlast ? HDR : PASS;
            end else begin
              wr_d    = cm_q;
              drop_d  = drop_q + 32'd1;
              state_d = s_axis_tlast ? HDR : DROP;
            end
          end else if (s_axis_tlast) begin
            wr_d   = cm_q;
            beat_d = 3'd0;
            ok_d   = 1'b1;
            drop_d = drop_q + 32'd1;
          end
        end
        PASS: begin
          we   = 1'b1;
          wr_d = wr_q + 1'b1;
          cm_d = wr_q + 1'b1;
          if (s_axis_tlast) state_d = HDR;
        end
        DROP: begin
          if (s_axis_tlast) state_d = HDR;
        end
        default: state_d = HDR;
      endcase
    end
  end

  // Filter state registers
  always_ff @(posedge clk156 or posedge sys_rst156) begin
    if (sys_rst156) begin
      state_q <= HDR;
      beat_q  <= 3'd0;
      ok_q    <= 1'b1;
      wr_q    <= '0;
      cm_q    <= '0;
      pass_q  <= 32'd0;
      drop_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ok_q    <= ok_d;
      wr_q    <= wr_d;
      cm_q    <= cm_d;
      pass_q  <= pass_d;
      drop_q  <= drop_d;
    end
  end

  // Beat storage
  always_ff @(posedge clk156) begin
    if (we) mem[wr_q[FIFO_AW-1:0]] <= wdata;
  end

  // Registered output: one committed beat per cycle
  always_ff @(posedge clk156 or posedge sys_rst156) begin
    if (sys_rst156) begin
      rd_q <= '0;
      mv_q <= 1'b0;
      ml_q <= 1'b0;
      mu_q <= 1'b0;
      mk_q <= 8'd0;
      md_q <= 64'd0;
    end else if (rd_q != cm_q) begin
      rd_q <= rd_q + 1'b1;
      mv_q <= 1'b1;
      {mu_q, ml_q, mk_q, md_q} <= mem[rd_q[FIFO_AW-1:0]];
    end else begin
      mv_q <= 1'b0;
    end
  end

  assign m_axis_tvalid = mv_q;
  assign m_axis_tlast  = ml_q;
  assign m_axis_tkeep  = mk_q;
  assign m_axis_tdata  = md_q;
  assign m_axis_tuser  = mu_q;
  assign pass_frames   = pass_q;
  assign drop_frames   = drop_q;

endmodule
